// File: rtl/frame_deframer_pkg.sv
// Shared constants and types for the byte-stuffed frame receiver and its consumer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_deframer_pkg;

    // Link-layer flag bytes
    localparam logic [7:0] FRAME_START = 8'h06;
    localparam logic [7:0] FRAME_END   = 8'h07;
    localparam logic [7:0] ESC_VAL     = 8'h14;
    localparam logic [7:0] ESC_XOR     = 8'h20;

    // Message code reported alongside every error pulse
    localparam logic [7:0] ERROR       = 8'h04;

    // Error cause encodings
    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_LEN   = 2'b01;
    localparam logic [1:0] CAUSE_CRC   = 2'b10;
    localparam logic [1:0] CAUSE_ESC   = 2'b11;

    // CRC-32/MPEG-2 seed
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_RECV,
        ST_ESC,
        ST_CHECK,
        ST_HOLD
    } state_e;

    // True for bytes that may never follow an escape byte
    function automatic logic is_delim(input logic [7:0] b);
        return (b == FRAME_START) || (b == FRAME_END);
    endfunction

endpackage

// File: rtl/frame_deframer_crc32_byte.sv
// One byte of a non-reflected CRC-32 shift register, MSB of the byte first.
// Latency: purely combinational.
// Backpressure: none.
module crc32_byte (
    input  logic [31:0] crc_i,
    input  logic [7:0]  byte_i,
    input  logic [31:0] poly_i,
    output logic [31:0] crc_o
);

    // Clock eight message bits through the LFSR, feeding back the polynomial on a 1.
    always_comb begin
        logic [31:0] c;
        c = crc_i;
        for (int i = 7; i >= 0; i--) begin
            if (c[31] ^ byte_i[i]) begin
                c = {c[30:0], 1'b0} ^ poly_i;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/frame_deframer.sv
// Strips byte stuffing from a serial byte stream, assembles a fixed-size frame and checks its CRC-32.
// Latency: frame_valid rises two clocks after the FRAME_END byte is presented.
// Backpressure: a checked frame is held until frame_ready; bytes arriving meanwhile are dropped and counted.
module frame_deframer
    import frame_deframer_pkg::*;
#(
    parameter int          FRAME_SIZE = 75,
    parameter logic [31:0] CRC_POLY   = 32'h04C1_1DB7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [0:FRAME_SIZE*8-1] frame_out,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    err_valid,
    output logic [7:0]              err_code,
    output logic [1:0]              err_cause,
    output logic [7:0]              drop_cnt
);

    localparam int               CNT_W        = $clog2(FRAME_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_SIZE);
    // Last byte index covered by the CRC; the trailing four bytes carry the CRC itself
    localparam logic [CNT_W-1:0] CNT_CRC_LAST = CNT_W'(FRAME_SIZE - 5);
    localparam int               CRC_BASE     = (FRAME_SIZE - 4) * 8;

    state_e                  st_q, st_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             crc_q, crc_d;
    logic [0:FRAME_SIZE*8-1] frame_q;
    logic                    err_vld_q, err_set;
    logic [7:0]              err_code_q;
    logic [1:0]              err_cause_q, cause_d;
    logic [7:0]              drop_q, drop_d;

    logic                    store;
    logic                    wr_en;
    logic [7:0]              wr_byte;
    logic [31:0]             crc_step;
    logic [31:0]             crc_rx;

    crc32_byte u_crc (
        .crc_i  (crc_q),
        .byte_i (wr_byte),
        .poly_i (CRC_POLY),
        .crc_o  (crc_step)
    );

    // CRC field as received, most significant byte first
    assign crc_rx = frame_q[CRC_BASE +: 32];

    // Next-state, store decision and error detection for the receive FSM.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        drop_d  = drop_q;
        store   = 1'b0;
        wr_en   = 1'b0;
        wr_byte = rx_data;
        err_set = 1'b0;
        cause_d = CAUSE_NONE;

        case (st_q)
            ST_HUNT: begin
                if (rx_valid && (rx_data == FRAME_START)) begin
                    st_d  = ST_RECV;
                    cnt_d = '0;
                    crc_d = CRC_INIT;
                end
            end
            ST_RECV: begin
                if (rx_valid) begin
                    if (rx_data == FRAME_END) begin
                        st_d = ST_CHECK;
                    end else if (rx_data == ESC_VAL) begin
                        st_d = ST_ESC;
                    end else if (rx_data == FRAME_START) begin
                        // A fresh start flag silently abandons the partial frame
                        cnt_d = '0;
                        crc_d = CRC_INIT;
                    end else begin
                        store = 1'b1;
                    end
                end
            end
            ST_ESC: begin
                if (rx_valid) begin
                    if (is_delim(rx_data)) begin
                        err_set = 1'b1;
                        cause_d = CAUSE_ESC;
                        st_d    = ST_HUNT;
                    end else begin
                        wr_byte = rx_data ^ ESC_XOR;
                        store   = 1'b1;
                        st_d    = ST_RECV;
                    end
                end
            end
            ST_CHECK: begin
                if (cnt_q != CNT_FULL) begin
                    err_set = 1'b1;
                    cause_d = CAUSE_LEN;
                    st_d    = ST_HUNT;
                end else if (crc_q != crc_rx) begin
                    err_set = 1'b1;
                    cause_d = CAUSE_CRC;
                    st_d    = ST_HUNT;
                end else begin
                    st_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (rx_valid && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                if (frame_ready) begin
                    st_d = ST_HUNT;
                end
            end
            default: begin
                st_d = ST_HUNT;
            end
        endcase

        // Shared store path for plain and unescaped bytes; overflow aborts the frame
        if (store) begin
            if (cnt_q == CNT_FULL) begin
                err_set = 1'b1;
                cause_d = CAUSE_LEN;
                st_d    = ST_HUNT;
            end else begin
                wr_en = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q <= CNT_CRC_LAST) begin
                    crc_d = crc_step;
                end
            end
        end
    end

    // FSM state, byte count, running CRC and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_HUNT;
            cnt_q  <= '0;
            crc_q  <= CRC_INIT;
            drop_q <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            crc_q  <= crc_d;
            drop_q <= drop_d;
        end
    end

    // Frame buffer doubles as the output register; it is never written while a frame is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (wr_en) begin
            frame_q[int'(cnt_q)*8 +: 8] <= wr_byte;
        end
    end

    // Error pulse plus sticky code and cause from the most recent error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vld_q   <= 1'b0;
            err_code_q  <= '0;
            err_cause_q <= CAUSE_NONE;
        end else begin
            err_vld_q <= err_set;
            if (err_set) begin
                err_code_q  <= ERROR;
                err_cause_q <= cause_d;
            end
        end
    end

    assign frame_out   = frame_q;
    assign frame_valid = (st_q == ST_HOLD);
    assign err_valid   = err_vld_q;
    assign err_code    = err_code_q;
    assign err_cause   = err_cause_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_frame_deframer.sv
// Randomized bench for frame_deframer with an in-bench queue-based reference model.
// Latency: n/a.
// Backpressure: frame_ready driven both deliberately and at random.
module tb_frame_deframer;

    localparam int          FS   = 13;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic            clk         = 1'b0;
    logic            rst_n       = 1'b0;
    logic [7:0]      rx_data     = 8'h00;
    logic            rx_valid    = 1'b0;
    logic            frame_ready = 1'b0;
    logic [0:FS*8-1] frame_out;
    logic            frame_valid;
    logic            err_valid;
    logic [7:0]      err_code;
    logic [1:0]      err_cause;
    logic [7:0]      drop_cnt;

    int n_chk      = 0;
    int n_fail     = 0;
    int fv_rises   = 0;
    int err_pulses = 0;
    bit cmp_en     = 1'b0;
    bit rdy_rand   = 1'b0;
    bit fv_prev    = 1'b0;

    // Reference model state
    logic [7:0]      mbuf[$];
    bit              m_in, m_esc, m_chk;
    logic            exp_fv, exp_errv;
    logic [7:0]      exp_code, exp_drop;
    logic [1:0]      exp_cause;
    logic [0:FS*8-1] exp_frame;

    frame_deframer #(.FRAME_SIZE(FS), .CRC_POLY(POLY)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .err_cause   (err_cause),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Plain CRC-32/MPEG-2 over the first n bytes of a queue
    function automatic logic [31:0] crc_ref(input logic [7:0] q[$], input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++) begin
            for (int i = 7; i >= 0; i--) begin
                logic fb;
                fb = c[31] ^ q[k][i];
                c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
            end
        end
        return c;
    endfunction

    task automatic m_reset();
        mbuf.delete();
        m_in = 0; m_esc = 0; m_chk = 0;
        exp_fv = 0; exp_errv = 0; exp_code = 8'h00; exp_cause = 2'b00;
        exp_drop = 8'h00; exp_frame = '0;
    endtask

    task automatic m_err(input logic [1:0] c);
        exp_errv = 1; exp_code = 8'h04; exp_cause = c;
        m_in = 0; m_esc = 0;
    endtask

    task automatic m_store(input logic [7:0] b);
        if (mbuf.size() == FS) m_err(2'b01);
        else mbuf.push_back(b);
    endtask

    // One clock of the reference: decide what the link layer must have done with this byte
    task automatic m_step();
        logic [31:0] rxc;
        exp_errv = 0;
        if (m_chk) begin
            m_chk = 0;
            if (mbuf.size() != FS) begin
                m_err(2'b01);
            end else begin
                rxc = 32'h0;
                for (int i = 0; i < 4; i++) rxc = {rxc[23:0], mbuf[FS-4+i]};
                if (crc_ref(mbuf, FS - 4) != rxc) begin
                    m_err(2'b10);
                end else begin
                    exp_fv = 1;
                    for (int i = 0; i < FS; i++) exp_frame[i*8 +: 8] = mbuf[i];
                end
            end
        end else if (exp_fv) begin
            if (rx_valid && exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
            if (frame_ready) exp_fv = 0;
        end else if (rx_valid) begin
            if (!m_in) begin
                if (rx_data == 8'h06) begin m_in = 1; mbuf.delete(); end
            end else if (m_esc) begin
                m_esc = 0;
                if (rx_data == 8'h06 || rx_data == 8'h07) m_err(2'b11);
                else m_store(rx_data ^ 8'h20);
            end else if (rx_data == 8'h07) begin
                m_in = 0; m_chk = 1;
            end else if (rx_data == 8'h14) begin
                m_esc = 1;
            end else if (rx_data == 8'h06) begin
                mbuf.delete();
            end else begin
                m_store(rx_data);
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // Per-cycle comparison against the model, plus event counters for the directed checks
    initial begin
        forever begin
            @(negedge clk);
            if (frame_valid && !fv_prev) fv_rises++;
            if (err_valid) err_pulses++;
            fv_prev = frame_valid;
            if (cmp_en) begin
                chk("cyc_frame_valid", 128'(frame_valid), 128'(exp_fv));
                if (exp_fv) chk("cyc_frame_out", 128'(frame_out), 128'(exp_frame));
                chk("cyc_err_valid", 128'(err_valid), 128'(exp_errv));
                chk("cyc_err_code", 128'(err_code), 128'(exp_code));
                chk("cyc_err_cause", 128'(err_cause), 128'(exp_cause));
                chk("cyc_drop_cnt", 128'(drop_cnt), 128'(exp_drop));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) frame_ready = ($urandom_range(0, 3) == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        for (int i = 0; i < q.size(); i++) send(q[i]);
    endtask

    task automatic send_gap(input logic [7:0] b);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send(b);
    endtask

    function automatic logic [7:0] rand_byte();
        int s;
        s = $urandom_range(0, 9);
        if (s == 0) return 8'h06;
        if (s == 1) return 8'h07;
        if (s == 2) return 8'h14;
        return 8'($urandom);
    endfunction

    // One randomly shaped frame: good, short/long, corrupted, restarted or escape-broken
    task automatic rand_frame();
        logic [7:0]  pl[$];
        logic [7:0]  b;
        logic [31:0] c;
        int          kind, n, pos;
        kind = $urandom_range(0, 9);
        n    = (kind == 7) ? $urandom_range(3, 11) : FS - 4;
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == 8'h06) b = 8'h00;
            send_gap(b);
        end
        if (kind == 6) begin
            send_gap(8'h06);
            send_gap(8'($urandom_range(8'h30, 8'h39)));
        end
        for (int i = 0; i < n; i++) pl.push_back(rand_byte());
        c = crc_ref(pl, (n < FS - 4) ? n : FS - 4);
        for (int i = 0; i < 4; i++) pl.push_back(c[31-8*i -: 8]);
        if (kind == 8) begin
            pos = $urandom_range(0, pl.size() - 1);
            pl[pos] = pl[pos] ^ 8'(1 << $urandom_range(0, 7));
        end
        pos = (kind == 9) ? $urandom_range(0, pl.size() - 1) : -1;
        send_gap(8'h06);
        for (int i = 0; i < pl.size(); i++) begin
            if (i == pos) begin
                send_gap(8'h14);
                send_gap(($urandom_range(0, 1) == 0) ? 8'h06 : 8'h07);
            end
            if (pl[i] == 8'h06 || pl[i] == 8'h07 || pl[i] == 8'h14 ||
                ($urandom_range(0, 9) == 0 && pl[i] != 8'h26 && pl[i] != 8'h27)) begin
                send_gap(8'h14);
                send_gap(pl[i] ^ 8'h20);
            end else begin
                send_gap(pl[i]);
            end
        end
        send_gap(8'h07);
    endtask

    initial begin
        logic [7:0]      good[$];
        logic [7:0]      bad[$];
        logic [7:0]      q[$];
        logic [0:FS*8-1] snap;
        int              lat, e0, f0;
        bit              stable;

        good = '{8'h06, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h03, 8'h76, 8'hE6, 8'hE7, 8'h07};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_frame_valid", 128'(frame_valid), 128'(0));
        chk("rst_err_valid", 128'(err_valid), 128'(0));
        chk("rst_err_code", 128'(err_code), 128'(0));
        chk("rst_err_cause", 128'(err_cause), 128'(0));
        chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
        chk("rst_frame_out", 128'(frame_out), 128'(0));

        q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model_crc_check_value", 128'(crc_ref(q, 9)), 128'h0376E6E7);

        cmp_en = 1'b1;

        // Known good frame, measured in edges from the FRAME_END byte
        f0 = fv_rises;
        send_q(good);
        lat = 1;
        while (!frame_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("good_latency", 128'(lat), 128'(2));
        chk("good_frame_out", 128'(frame_out), 128'h3132333435363738390376E6E7);

        // Hold with no consumer: five bytes dropped, output frozen
        snap   = frame_out;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c % 4 == 1) begin
                rx_data  = (c == 5) ? 8'h06 : 8'(8'hA0 + c);
                rx_valid = 1'b1;
            end
            tick();
            rx_valid = 1'b0;
            if (frame_out !== snap || frame_valid !== 1'b1) stable = 1'b0;
        end
        chk("hold_stable", 128'(stable), 128'(1));
        chk("hold_drop_cnt", 128'(drop_cnt), 128'(5));
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk("hold_release", 128'(frame_valid), 128'(0));
        chk("good_one_frame", 128'(fv_rises - f0), 128'(1));

        // CRC error
        bad = good;
        bad[12] = 8'hE5;
        e0 = err_pulses; f0 = fv_rises;
        send_q(bad);
        idle(4);
        chk("crc_err_pulse", 128'(err_pulses - e0), 128'(1));
        chk("crc_no_frame", 128'(fv_rises - f0), 128'(0));
        chk("crc_err_code", 128'(err_code), 128'h04);
        chk("crc_err_cause", 128'(err_cause), 128'(2'b10));

        // Escape error
        e0 = err_pulses;
        q = '{8'h06, 8'h31, 8'h14, 8'h07};
        send_q(q);
        idle(3);
        chk("esc_err_pulse", 128'(err_pulses - e0), 128'(1));
        chk("esc_err_cause", 128'(err_cause), 128'(2'b11));

        // Short frame
        e0 = err_pulses;
        q = '{8'h06, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
              8'h4A, 8'h4B, 8'h4C, 8'h07};
        send_q(q);
        idle(3);
        chk("len_err_pulse", 128'(err_pulses - e0), 128'(1));
        chk("len_err_cause", 128'(err_cause), 128'(2'b01));

        // Restart mid-frame
        e0 = err_pulses; f0 = fv_rises;
        q = '{8'h06, 8'h31, 8'h32};
        send_q(q);
        send_q(good);
        idle(3);
        chk("restart_one_frame", 128'(fv_rises - f0), 128'(1));
        chk("restart_no_err", 128'(err_pulses - e0), 128'(0));
        chk("restart_frame_out", 128'(frame_out), 128'h3132333435363738390376E6E7);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;

        // Asynchronous reset mid-frame
        q = '{8'h06, 8'h31, 8'h32, 8'h33};
        send_q(q);
        e0 = err_pulses;
        rst_n = 1'b0;
        #2;
        chk("arst_frame_valid", 128'(frame_valid), 128'(0));
        chk("arst_err_valid", 128'(err_valid), 128'(0));
        chk("arst_err_code", 128'(err_code), 128'(0));
        chk("arst_err_cause", 128'(err_cause), 128'(0));
        chk("arst_drop_cnt", 128'(drop_cnt), 128'(0));
        chk("arst_frame_out", 128'(frame_out), 128'(0));
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("arst_no_err", 128'(err_pulses - e0), 128'(0));
        send_q(good);
        idle(2);
        chk("arst_next_frame", 128'(frame_valid), 128'(1));
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;

        // Randomized traffic with random consumer backpressure
        rdy_rand = 1'b1;
        for (int f = 0; f < 250; f++) rand_frame();
        rdy_rand    = 1'b0;
        frame_ready = 1'b1;
        idle(4);
        frame_ready = 1'b0;

        // Drop counter saturation
        send_q(good);
        idle(2);
        chk("sat_frame_valid", 128'(frame_valid), 128'(1));
        for (int i = 0; i < 260; i++) send(8'($urandom));
        chk("sat_drop_cnt", 128'(drop_cnt), 128'(255));
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_deframer.md
FRAME_DEFRAMER -- requirements
Module: frame_deframer

Interface
REQ-001 SHALL have parameter FRAME_SIZE, default 75, meaning unstuffed frame length in bytes, including the trailing 4-byte CRC.
REQ-002 SHALL have parameter CRC_POLY, default 32'h04C11DB7, meaning the CRC-32 generator polynomial.
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data, input, 8 bits: byte from the serial receiver.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle qualifier for rx_data.
REQ-007 SHALL have port frame_out, output, [0:FRAME_SIZE*8-1]: assembled frame, byte 0 at bits [0:7].
REQ-008 SHALL have port frame_valid, output, 1 bit: frame_out holds a checked frame.
REQ-009 SHALL have port frame_ready, input, 1 bit: the consumer (Core) accepts the frame.
REQ-010 SHALL have port err_valid, output, 1 bit: one-cycle error pulse.
REQ-011 SHALL have port err_code, output, 8 bits: fixed 8'h04 (ERROR) whenever err_valid is high.
REQ-012 SHALL have port err_cause, output, 2 bits: 01 = length, 10 = CRC, 11 = escape.
REQ-013 SHALL have port drop_cnt, output, 8 bits: count of bytes dropped in HOLD, saturating at 255.

Function
REQ-014 SHALL implement states HUNT, RECV, ESC, CHECK and HOLD; rx bytes are acted on only when rx_valid=1.
REQ-015 HUNT: 8'h06 (FRAME_START) SHALL clear the byte count, set crc to 32'hFFFFFFFF and go to RECV; all other bytes SHALL be ignored.
REQ-016 RECV:
- 8'h07 SHALL go to CHECK.
- 8'h14 SHALL go to ESC.
- 8'h06 SHALL restart the frame (count clear, crc init, no error).
- Any other byte SHALL be stored.
REQ-017 ESC: the byte XOR 8'h20 SHALL be stored and the state SHALL return to RECV; 8'h06 or 8'h07 in ESC SHALL raise an escape error and go to HUNT.
REQ-018 Store rule: the byte SHALL be written at index count and count SHALL increment.
- If the store would make count exceed FRAME_SIZE, a length error SHALL be raised and the state SHALL go to HUNT.
REQ-019 CRC SHALL be updated MSB-first over byte indices 0..FRAME_SIZE-5 only: no reflection, no final XOR (CRC-32/MPEG-2).
REQ-020 CHECK SHALL last one cycle and branch as follows:
- count != FRAME_SIZE SHALL raise a length error.
- Otherwise, crc != bytes FRAME_SIZE-4..FRAME_SIZE-1 (big-endian) SHALL raise a CRC error.
- Otherwise the state SHALL go to HOLD with frame_valid=1.
- After either error the state SHALL go to HUNT.
REQ-021 frame_valid SHALL rise on the cycle after the FRAME_END byte is accepted, giving 2-cycle latency from the 8'h07 byte.
REQ-022 HOLD: frame_valid and frame_out SHALL stay stable until frame_valid && frame_ready; the next cycle SHALL have frame_valid=0 and state HUNT.
REQ-023 HOLD: every rx_valid byte SHALL be dropped and SHALL increment drop_cnt; a FRAME_START byte in HOLD is also dropped.
REQ-024 err_valid SHALL be a one-cycle pulse on the cycle after the offending byte (or after CHECK); err_code and err_cause SHALL hold their values until the next error.
REQ-025 frame_ready while not in HOLD SHALL be ignored.
REQ-026 rx_valid and frame_ready in the same HOLD cycle: the byte SHALL be dropped and the handshake SHALL complete.

Reset
REQ-027 rst_n=0 SHALL asynchronously force the following values, and SHALL abandon any partial frame without raising an error:
- state HUNT
- frame_valid 0
- err_valid 0
- err_code 0
- err_cause 0
- drop_cnt 0
- frame_out all zeros
- count 0
- crc 32'hFFFFFFFF
REQ-028 Release of reset SHALL take effect on the first clk edge with rst_n=1.

Structure
REQ-029 Flag bytes (FRAME_START 06, FRAME_END 07, ESC_VAL 14, ESC_XOR 20), ERROR 04 and the err_cause encodings SHALL live in the shared package used by Core.
REQ-030 The byte-wise CRC step SHALL be one combinational sub-module crc32_byte (crc_in, byte, poly -> crc_out).

Verification (FRAME_SIZE=13)
REQ-031 Bytes 06 31 32 33 34 35 36 37 38 39 03 76 E6 E7 07 SHALL produce frame_valid with frame_out=0x3132333435363738390376E6E7, 2 cycles after byte 07.
REQ-032 Same frame with E6 changed to E5 SHALL produce err_valid, err_code=04, err_cause=10, and no frame_valid.
REQ-033 Bytes 06 31 14 07 SHALL produce err_cause=11 and state HUNT; bytes 06 + 12 data bytes + 07 SHALL produce err_cause=01.
REQ-034 Bytes 06 31 32 followed by the valid frame from REQ-031 SHALL produce exactly one frame_valid and no error.
REQ-035 With frame_ready=0 for 20 cycles and 5 bytes sent, frame_valid and frame_out SHALL stay stable and drop_cnt SHALL be 5; one frame_ready cycle SHALL release HOLD.
REQ-036 rst_n pulsed low mid-frame SHALL return all outputs to reset values with no err_valid; a following valid frame SHALL be accepted.
